// File: rtl/l1a_checker_part2.sv
// Per-channel L1A event-number checker driven by the sequencer's one-hot token.
// Flags mismatches and header timeouts, then pulses one_adc_finish_check so the token can advance.
module l1a_checker_part2 #(
  parameter int NUM_ADC = 16,
  parameter int EVT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_ADC-1:0]       start_check,
  input  logic [NUM_ADC-1:0]       adc_evt_valid,
  input  logic [NUM_ADC*EVT_W-1:0] adc_evt_num,
  output logic                     one_adc_finish_check,
  output logic [EVT_W-1:0]         expected_evt,
  output logic [NUM_ADC-1:0]       mismatch_mask,
  output logic [NUM_ADC-1:0]       timeout_mask,
  output logic [2:0]               error,
  output logic                     busy
);

  localparam int IDX_W = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
  localparam int CNT_W = 10;
  localparam logic [IDX_W-1:0] LAST_CH     = IDX_W'(NUM_ADC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_HDR, DONE, GAP} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ch, ch_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]   low_idx;
  logic               one_hot;
  logic [EVT_W-1:0]   evt_arr [NUM_ADC];
  logic               finish_next;
  logic [EVT_W-1:0]   expected_next;
  logic [NUM_ADC-1:0] mismatch_next, timeout_next;
  logic [2:0]         error_next;

  // Lowest set bit wins, so an illegal multi-hot token still selects one channel.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ADC - 1; i >= 0; i--) begin
      if (start_check[i]) low_idx = IDX_W'(i);
    end
  end

  assign one_hot = ((start_check & (start_check - 1'b1)) == '0);

  always_comb begin
    for (int i = 0; i < NUM_ADC; i++) evt_arr[i] = adc_evt_num[i*EVT_W +: EVT_W];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next    = state;
    ch_next       = ch;
    cnt_next      = cnt;
    finish_next   = 1'b0;
    expected_next = expected_evt;
    mismatch_next = mismatch_mask;
    timeout_next  = timeout_mask;
    error_next    = error;
    case (state)
      IDLE: begin
        if (start_check != '0) begin
          ch_next    = low_idx;
          cnt_next   = '0;
          state_next = WAIT_HDR;
          if (!one_hot) error_next[2] = 1'b1;
        end
      end
      WAIT_HDR: begin
        if (start_check == '0) begin
          state_next = IDLE;
        end else if (adc_evt_valid[ch]) begin
          if (evt_arr[ch] != expected_evt) begin
            mismatch_next[ch] = 1'b1;
            error_next[0]     = 1'b1;
          end
          finish_next = 1'b1;
          state_next  = DONE;
        end else if (cnt == TIMEOUT_CNT) begin
          timeout_next[ch] = 1'b1;
          error_next[1]    = 1'b1;
          finish_next      = 1'b1;
          state_next       = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        if (ch == LAST_CH) expected_next = expected_evt + 1'b1;
        state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state                <= IDLE;
      ch                   <= '0;
      cnt                  <= '0;
      one_adc_finish_check <= 1'b0;
      expected_evt         <= '0;
      mismatch_mask        <= '0;
      timeout_mask         <= '0;
      error                <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_next;
      ch                   <= ch_next;
      cnt                  <= cnt_next;
      one_adc_finish_check <= finish_next;
      expected_evt         <= expected_next;
      mismatch_mask        <= mismatch_next;
      timeout_mask         <= timeout_next;
      error                <= error_next;
      busy                 <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/l1a_checker_part2.md
Name: l1a_checker_part2

Overview:
Downstream consumer of the one-hot check token (start_check) from the L1A checker sequencer.
- For the single ADC channel selected by the token, waits for that channel's event-header strobe.
- Compares the channel's reported L1A event number against an internally tracked expected number.
- Records mismatch/timeout errors, then returns a one-cycle one_adc_finish_check pulse so the sequencer shifts the token to the next ADC.

Parameters:
- NUM_ADC, 16: number of ADC channels; equals the token width.
- EVT_W, 16: width of the L1A event number.
- TIMEOUT, 1023: maximum cycles to wait for a header strobe; 10-bit counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_check  in  NUM_ADC  one-hot token from the sequencer; all-zero means idle.
- adc_evt_valid  in  NUM_ADC  per-channel one-cycle strobe: header event number valid.
- adc_evt_num  in  NUM_ADC*EVT_W  flattened event numbers; channel k occupies bits [k*EVT_W +: EVT_W].
- one_adc_finish_check  out  1  one-cycle pulse: current channel check complete.
- expected_evt  out  EVT_W  expected event number for the current token pass.
- mismatch_mask  out  NUM_ADC  sticky per-channel mismatch flags.
- timeout_mask  out  NUM_ADC  sticky per-channel timeout flags.
- error  out  3  sticky summary: [0] any mismatch, [1] any timeout, [2] token not one-hot.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
Reset (synchronous, active-high, wins over all other inputs):
- All outputs go to 0, expected_evt included; the FSM enters IDLE.
- Reset asserted mid-check aborts the check with no finish pulse.

FSM states are IDLE, WAIT_HDR, DONE and GAP. All outputs are registered.

IDLE:
- start_check == 0: stay in IDLE.
- start_check nonzero and not one-hot:
  - set error[2];
  - latch the lowest set bit as channel k;
  - proceed as for the one-hot case.
- start_check one-hot at bit k:
  - latch channel index k;
  - clear the timeout counter;
  - go to WAIT_HDR on the next edge.

WAIT_HDR:
- adc_evt_valid[k] == 1:
  - compare adc_evt_num[k] with expected_evt;
  - if they are unequal, set mismatch_mask[k] and error[0];
  - go to DONE.
- Valids on other channels are ignored.
- Timeout counter reaches TIMEOUT:
  - set timeout_mask[k] and error[1];
  - go to DONE.
- Valid and timeout in the same cycle: the valid wins, no timeout is recorded.
- Latency from the token appearing to the earliest compare is 1 cycle. Latency to the finish pulse is 2 cycles minimum.

DONE:
- one_adc_finish_check = 1 for exactly this cycle.
- If k == NUM_ADC-1, expected_evt increments by 1, wrapping modulo 2^EVT_W (0xFFFF -> 0x0000).
- Next state is GAP.

GAP:
- Exactly one cycle with start_check ignored, so the sequencer's shifted token settles.
- Next state is IDLE.

Other rules:
- Token disappears (start_check == 0) while in WAIT_HDR: abort to IDLE with no pulse, no error and no expected_evt change.
- Sticky flags are cleared only by reset.
- Per-channel throughput is one check every 4 cycles minimum.

Test Plan:
1. Clean pass:
   - Stimulus: reset; token 0x0001 shifting once per finish pulse; each channel returns evt_num 0 one cycle after its token.
   - Required: 16 finish pulses each 4 cycles apart; mismatch_mask=0; error=0; expected_evt=1 after the channel-15 pulse.
2. Mismatch:
   - Stimulus: second event pass, channel 5 reports 0x0007 while expected_evt=1.
   - Required: mismatch_mask=0x0020; error=3'b001; chain still completes; expected_evt=2.
3. Timeout:
   - Stimulus: channel 3 never strobes valid.
   - Required: finish pulse exactly 1 cycle after the counter reaches 1023; timeout_mask=0x0008; error[1]=1; subsequent channels are checked normally.
4. Wrap and simultaneity:
   - Stimulus: preload to expected_evt=0xFFFF by driving passes, then complete channel 15; separately, assert valid on the timeout cycle.
   - Required: expected_evt=0x0000 after the wrap; the coinciding valid wins with no timeout flag.
5. Illegal token:
   - Stimulus: start_check=0x0006.
   - Required: error[2]=1; channel 1 is checked; one finish pulse.
6. Reset mid-check:
   - Stimulus: assert reset while in WAIT_HDR on channel 7.
   - Required: no finish pulse; all outputs 0 on the next cycle; busy=0.
